// File: rtl/rr_arbiter_16_pkg.sv
// Shared types and constants for the 16-way round-robin arbiter.
// Optional forced-release feature is enabled with ARB_TIMEOUT_EN.
package rr_arbiter_16_pkg;
    localparam int ARB_N       = 16;
    localparam int ARB_IDXW    = 4;
    localparam int ARB_TIMEOUT = 255;

    typedef logic [ARB_N-1:0]    vec_t;
    typedef logic [ARB_IDXW-1:0] idx_t;

    typedef enum logic {
        ARB_S_IDLE  = 1'b0,
        ARB_S_GRANT = 1'b1
    } state_t;

    function automatic vec_t onehot(idx_t i);
        return vec_t'(1) << i;
    endfunction
endpackage

// File: rtl/rr_arbiter_16_if.sv
// Request/grant bundle between requesting agents (master)
// and the arbiter (slave).
interface rr_arbiter_16_if;
    import rr_arbiter_16_pkg::*;

    logic enable;
    vec_t req;
    logic done;
    vec_t grant;
    idx_t grant_idx;
    logic grant_valid;
    logic timeout;

    modport master (
        output enable, req, done,
        input  grant, grant_idx, grant_valid, timeout
    );

    modport slave (
        input  enable, req, done,
        output grant, grant_idx, grant_valid, timeout
    );
endinterface

// File: rtl/rr_arbiter_16_prio_enc16.sv
// 16->4 lowest-set-bit encoder with a valid flag.
// Purely combinational; bit k encodes to index k.
module arb_prio_enc16
    import rr_arbiter_16_pkg::*;
(
    input  vec_t in,
    output idx_t idx,
    output logic valid
);
    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = ARB_N - 1; i >= 0; i--) begin
            if (in[i]) begin
                idx   = idx_t'(i);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter, 16 requesters, held grant released by done or req drop.
// Define ARB_TIMEOUT_EN to force release after TIMEOUT grant cycles.
module rr_arbiter_16
    import rr_arbiter_16_pkg::*;
#(
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter_16_if.slave bus
);
    state_t state;
    idx_t   ptr;
    vec_t   grant_q;
    idx_t   idx_q;
    logic   valid_q;

    vec_t   masked;
    idx_t   m_idx;
    idx_t   r_idx;
    logic   m_valid;
    logic   r_valid;
    idx_t   win_idx;
    idx_t   ptr_next;
    logic   rel;

    // Requests at or above the pointer get first pick; otherwise wrap.
    assign masked   = bus.req & (vec_t'('1) << ptr);
    assign win_idx  = m_valid ? m_idx : r_idx;
    assign ptr_next = idx_q + idx_t'(1);
    assign rel      = bus.done | ~bus.req[idx_q];

    arb_prio_enc16 u_enc_masked (
        .in    (masked),
        .idx   (m_idx),
        .valid (m_valid)
    );

    arb_prio_enc16 u_enc_raw (
        .in    (bus.req),
        .idx   (r_idx),
        .valid (r_valid)
    );

`ifdef ARB_TIMEOUT_EN
    logic [15:0] hold_cnt;
    logic        timeout_q;
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_S_IDLE;
            ptr       <= '0;
            grant_q   <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            unique case (state)
                ARB_S_IDLE: begin
                    if (bus.enable && r_valid) begin
                        state    <= ARB_S_GRANT;
                        grant_q  <= onehot(win_idx);
                        idx_q    <= win_idx;
                        valid_q  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                ARB_S_GRANT: begin
                    if (rel) begin
                        state   <= ARB_S_IDLE;
                        ptr     <= ptr_next;
                        grant_q <= '0;
                        idx_q   <= '0;
                        valid_q <= 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (hold_cnt == 16'(TIMEOUT - 1)) begin
                        state     <= ARB_S_IDLE;
                        ptr       <= ptr_next;
                        grant_q   <= '0;
                        idx_q     <= '0;
                        valid_q   <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
`endif
                end
                default: state <= ARB_S_IDLE;
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout     = timeout_q;
`else
    assign bus.timeout     = 1'b0;
`endif
endmodule
